// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM stage: byte-mode codes, FSM states, access sizes.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_pkg;

    localparam logic [2:0] BMC_B  = 3'b000;
    localparam logic [2:0] BMC_H  = 3'b001;
    localparam logic [2:0] BMC_W  = 3'b010;
    localparam logic [2:0] BMC_BU = 3'b100;
    localparam logic [2:0] BMC_HU = 3'b101;

    localparam int TIMEOUT_W = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } acc_size_t;

    // Unlisted funct3 codes are treated as full-word, unextended accesses.
    function automatic acc_size_t bmc_size(input logic [2:0] bmc);
        case (bmc)
            BMC_B, BMC_BU: return SZ_B;
            BMC_H, BMC_HU: return SZ_H;
            BMC_W:         return SZ_W;
            default:       return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables/replicated data, load lane select + extension, misalignment.
// Latency: combinational.
// Backpressure: none.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  bmc,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_ext,
    output logic        misaligned
);

    acc_size_t   size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        size       = bmc_size(bmc);
        be         = 4'b1111;
        wdata      = st_data;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                be    = 4'b0001 << off;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{st_data[15:0]}};
                misaligned = off[0];
            end
            default: misaligned = |off;
        endcase
    end

    always_comb begin
        ld_byte = ld_data[{off, 3'b000} +: 8];
        ld_half = off[1] ? ld_data[31:16] : ld_data[15:0];
        case (bmc)
            BMC_B:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            BMC_BU:  ld_ext = {24'h0, ld_byte};
            BMC_H:   ld_ext = {{16{ld_half[15]}}, ld_half};
            BMC_HU:  ld_ext = {16'h0, ld_half};
            default: ld_ext = ld_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues loads/stores on a req/ack port, aligns data, registers the MEM/WB bundle.
// Latency: non-memory ops 1 cycle; memory ops 1 issue cycle + ack wait, WB valid the cycle after ack.
// Backpressure: mem_stall holds upstream from issue until ack (or timeout); misaligned ops never stall.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_Pc4,
    input  logic [31:0] MEM_Fout,
    input  logic [31:0] MEM_Data_Out,
    input  logic [4:0]  MEM_DA,
    input  logic        MEM_MD,
    input  logic        MEM_RW,
    input  logic        MEM_MW,
    input  logic        MEM_MR,
    input  logic        MEM_JL,
    input  logic        MEM_JLR,
    input  logic [2:0]  MEM_BMC,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err,
    output logic [31:0] WB_Result,
    output logic [4:0]  WB_DA,
    output logic        WB_RW
);

    mem_state_t           state, state_nxt;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic [2:0]  cap_bmc;
    logic [4:0]  cap_da;
    logic        cap_we, cap_rw, cap_md;

    logic        busy, access, issue, drop, ack_hit, tmo_hit;
    logic [1:0]  aln_off;
    logic [2:0]  aln_bmc;
    logic [3:0]  aln_be;
    logic [31:0] aln_wdata, aln_ld;
    logic        aln_mis;

    assign busy   = (state == BUSY);
    assign access = MEM_MR | MEM_MW;

    // While BUSY the aligner serves the captured access for load extension.
    assign aln_off = busy ? cap_addr[1:0] : MEM_Fout[1:0];
    assign aln_bmc = busy ? cap_bmc : MEM_BMC;

    load_store_align u_align (
        .off        (aln_off),
        .bmc        (aln_bmc),
        .st_data    (MEM_Data_Out),
        .ld_data    (dmem_rdata),
        .be         (aln_be),
        .wdata      (aln_wdata),
        .ld_ext     (aln_ld),
        .misaligned (aln_mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        issue     = 1'b0;
        drop      = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps the combinational stall quiet while reset is held.
                if (access && rst) begin
                    if (aln_mis) begin
                        drop = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        mem_stall = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_stall = ~dmem_ack;
                if (dmem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   tmo_cnt <= '0;
        else if (issue)             tmo_cnt <= '0;
        else if (busy && !dmem_ack) tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            cap_bmc   <= '0;
            cap_da    <= '0;
            cap_we    <= 1'b0;
            cap_rw    <= 1'b0;
            cap_md    <= 1'b0;
        end else if (issue) begin
            cap_addr  <= MEM_Fout;
            cap_wdata <= aln_wdata;
            cap_be    <= aln_be;
            cap_bmc   <= MEM_BMC;
            cap_da    <= MEM_DA;
            cap_we    <= MEM_MW;
            cap_rw    <= MEM_RW;
            cap_md    <= MEM_MD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_Result    <= '0;
            WB_DA        <= '0;
            WB_RW        <= 1'b0;
            mem_misalign <= 1'b0;
            mem_bus_err  <= 1'b0;
        end else begin
            mem_misalign <= drop;
            mem_bus_err  <= tmo_hit;
            if (ack_hit) begin
                WB_Result <= cap_md ? aln_ld : cap_addr;
                WB_DA     <= cap_da;
                WB_RW     <= cap_rw;
            end else if (busy) begin
                WB_RW <= 1'b0;
            end else if (access) begin
                // Issue cycle and dropped misaligned access both leave a bubble.
                WB_DA <= MEM_DA;
                WB_RW <= 1'b0;
            end else begin
                WB_Result <= (MEM_JL | MEM_JLR) ? MEM_Pc4 : MEM_Fout;
                WB_DA     <= MEM_DA;
                WB_RW     <= MEM_RW;
            end
        end
    end

    assign dmem_req   = busy;
    assign dmem_we    = busy & cap_we;
    assign dmem_addr  = busy ? {cap_addr[31:2], 2'b00} : '0;
    assign dmem_wdata = busy ? cap_wdata : '0;
    assign dmem_be    = busy ? cap_be : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model of the MEM stage.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk, rst;
    logic [31:0] MEM_Pc4, MEM_Fout, MEM_Data_Out;
    logic [4:0]  MEM_DA;
    logic        MEM_MD, MEM_RW, MEM_MW, MEM_MR, MEM_JL, MEM_JLR;
    logic [2:0]  MEM_BMC;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        mem_stall, mem_misalign, mem_bus_err;
    logic [31:0] WB_Result;
    logic [4:0]  WB_DA;
    logic        WB_RW;

    int n_cmp = 0;
    int n_mis = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .MEM_Pc4(MEM_Pc4), .MEM_Fout(MEM_Fout), .MEM_Data_Out(MEM_Data_Out),
        .MEM_DA(MEM_DA), .MEM_MD(MEM_MD), .MEM_RW(MEM_RW), .MEM_MW(MEM_MW),
        .MEM_MR(MEM_MR), .MEM_JL(MEM_JL), .MEM_JLR(MEM_JLR), .MEM_BMC(MEM_BMC),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .mem_stall(mem_stall), .mem_misalign(mem_misalign),
        .mem_bus_err(mem_bus_err), .WB_Result(WB_Result), .WB_DA(WB_DA), .WB_RW(WB_RW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes from funct3.
    function automatic int sz(input logic [2:0] bmc);
        case (bmc)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input int off, input logic [2:0] bmc);
        if (sz(bmc) == 1) return 4'(1 << off);
        if (sz(bmc) == 2) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] bmc);
        if (sz(bmc) == 1) return 32'h01010101 * {24'h0, d[7:0]};
        if (sz(bmc) == 2) return 32'h00010001 * {16'h0, d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input logic [2:0] bmc);
        logic [31:0] v, mask;
        if (sz(bmc) == 4) return rd;
        v    = rd >> (8 * off);
        mask = (sz(bmc) == 1) ? 32'hFF : 32'hFFFF;
        v    = v & mask;
        if (!bmc[2] && (v > (mask >> 1))) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_nop();
        MEM_Pc4 = 0; MEM_Fout = 0; MEM_Data_Out = 0; MEM_DA = 0; MEM_MD = 0; MEM_RW = 0;
        MEM_MW = 0; MEM_MR = 0; MEM_JL = 0; MEM_JLR = 0; MEM_BMC = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // ack_at: BUSY cycle (1..TMO) carrying ack, or 0 for no ack at all.
    task automatic do_op(input logic [31:0] pc4, input logic [31:0] fout, input logic [31:0] data,
                         input logic [4:0] da, input logic md, input logic rw, input logic mw,
                         input logic mr, input logic jl, input logic jlr, input logic [2:0] bmc,
                         input int ack_at, input logic [31:0] rdata, input logic idle_ack);
        int  off, stalls, reqs;
        bit  acc, mis, done;
        @(negedge clk);
        MEM_Pc4 = pc4; MEM_Fout = fout; MEM_Data_Out = data; MEM_DA = da; MEM_MD = md;
        MEM_RW = rw; MEM_MW = mw; MEM_MR = mr; MEM_JL = jl; MEM_JLR = jlr; MEM_BMC = bmc;
        acc = mr | mw;
        off = int'(fout[1:0]);
        mis = acc && ((off % sz(bmc)) != 0);
        dmem_ack   = acc ? 1'b0 : idle_ack;
        dmem_rdata = $urandom;
        #1;
        if (!acc || mis) begin
            check_val("stall_nomem", mem_stall, 0);
            check_val("req_nomem", dmem_req, 0);
            @(posedge clk); #1;
            dmem_ack = 0;
            if (mis) begin
                check_val("misalign_pulse", mem_misalign, 1);
                check_val("wb_rw_mis", WB_RW, 0);
            end else begin
                check_val("wb_result_alu", WB_Result, (jl | jlr) ? pc4 : fout);
                check_val("wb_da_alu", WB_DA, da);
                check_val("wb_rw_alu", WB_RW, rw);
                check_val("misalign_quiet", mem_misalign, 0);
            end
            check_val("bus_err_quiet", mem_bus_err, 0);
            return;
        end
        check_val("stall_issue", mem_stall, 1);
        check_val("req_issue", dmem_req, 0);
        @(posedge clk); #1;
        check_val("wb_bubble", WB_RW, 0);
        stalls = 1; reqs = 0; done = 0;
        for (int k = 1; k <= TMO + 2 && !done; k++) begin
            @(negedge clk);
            if (dmem_req) reqs++;
            if (k == 1) begin
                check_val("dmem_addr", dmem_addr, fout & ~32'h3);
                check_val("dmem_we", dmem_we, mw);
                check_val("dmem_be", dmem_be, exp_be(off, bmc));
                check_val("dmem_wdata", dmem_wdata, exp_wdata(data, bmc));
            end
            if (k == ack_at) begin
                dmem_ack   = 1;
                dmem_rdata = rdata;
            end
            #1;
            if (mem_stall) stalls++;
            @(posedge clk); #1;
            dmem_ack   = 0;
            dmem_rdata = $urandom;
            if (!dmem_req) done = 1;
        end
        check_val("completes", done, 1);
        if (ack_at != 0) begin
            check_val("req_cycles", reqs, ack_at);
            check_val("stall_cycles", stalls, ack_at);
            check_val("wb_result_mem", WB_Result, md ? exp_load(rdata, off, bmc) : fout);
            check_val("wb_da_mem", WB_DA, da);
            check_val("wb_rw_mem", WB_RW, rw);
            check_val("bus_err_none", mem_bus_err, 0);
        end else begin
            check_val("req_cycles_tmo", reqs, TMO);
            check_val("stall_cycles_tmo", stalls, TMO + 1);
            check_val("bus_err_pulse", mem_bus_err, 1);
            check_val("wb_rw_tmo", WB_RW, 0);
        end
        check_val("misalign_none", mem_misalign, 0);
        // Upstream advances past the finished access.
        drive_nop();
        #1;
        check_val("stall_released", mem_stall, 0);
    endtask

    logic [2:0] bmc_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        int kind, ack_at;
        logic mr, mw, md, rw;
        logic [31:0] fout;

        rst = 0;
        drive_nop();
        MEM_MR = 1; MEM_Fout = 32'h100; MEM_BMC = 3'b010; MEM_RW = 1;
        #3;
        check_val("rst_req", dmem_req, 0);
        check_val("rst_stall", mem_stall, 0);
        check_val("rst_wb_result", WB_Result, 0);
        check_val("rst_wb_rw", WB_RW, 0);
        check_val("rst_flags", {mem_misalign, mem_bus_err}, 0);
        drive_nop();
        @(negedge clk); rst = 1;

        // pc4, fout, data, da, md, rw, mw, mr, jl, jlr, bmc, ack_at, rdata, idle_ack
        do_op(0, 32'h100, 0, 5'd3, 1, 1, 0, 1, 0, 0, 3'b010, 3, 32'hDEADBEEF, 0);
        do_op(0, 32'h103, 0, 5'd4, 1, 1, 0, 1, 0, 0, 3'b000, 1, 32'h80FF0000, 0);
        do_op(0, 32'h103, 0, 5'd4, 1, 1, 0, 1, 0, 0, 3'b100, 2, 32'h80FF0000, 0);
        do_op(0, 32'h202, 32'h1234ABCD, 5'd0, 0, 0, 1, 0, 0, 0, 3'b001, 1, 0, 0);
        do_op(0, 32'h101, 0, 5'd6, 1, 1, 0, 1, 0, 0, 3'b010, 1, 0, 0);
        do_op(0, 32'h400, 0, 5'd7, 1, 1, 0, 1, 0, 0, 3'b010, 0, 0, 0);
        do_op(0, 32'h404, 0, 5'd8, 1, 1, 0, 1, 0, 0, 3'b101, TMO, 32'hF00D8001, 0);
        do_op(0, 32'h500, 32'hAA, 5'd9, 0, 1, 1, 1, 0, 0, 3'b000, 2, 32'h11223344, 0);
        do_op(32'h44, 32'h999, 0, 5'd1, 0, 1, 0, 0, 1, 0, 3'b000, 0, 0, 1);

        for (int i = 0; i < 80; i++) begin
            kind   = $urandom_range(0, 3);
            fout   = $urandom;
            ack_at = $urandom_range(0, TMO);
            mr = 0; mw = 0; md = 0; rw = 1'($urandom);
            if (kind == 1 || kind == 3) begin
                mr = 1; md = 1'($urandom);
            end else if (kind == 2) begin
                mw = 1; mr = 1'($urandom); rw = 0;
            end
            do_op($urandom, fout, $urandom, 5'($urandom), md, rw, mw, mr,
                  1'($urandom), 1'($urandom), bmc_tab[$urandom_range(0, 7)],
                  ack_at, $urandom, 1'($urandom));
        end

        // Reset while an access is outstanding.
        do_op(32'h44, 32'h0, 0, 5'd2, 0, 1, 0, 0, 1, 0, 3'b000, 0, 0, 0);
        @(negedge clk);
        MEM_MR = 1; MEM_Fout = 32'h300; MEM_BMC = 3'b010; MEM_RW = 1; MEM_MD = 1; MEM_DA = 5'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("busy_before_rst", dmem_req, 1);
        #2;
        rst = 0;
        #1;
        check_val("rst_mid_req", dmem_req, 0);
        check_val("rst_mid_stall", mem_stall, 0);
        check_val("rst_mid_addr", dmem_addr, 0);
        check_val("rst_mid_be", dmem_be, 0);
        check_val("rst_mid_wb", {WB_Result, 5'(WB_DA), 1'(WB_RW)}, 0);
        drive_nop();
        @(negedge clk); rst = 1;
        do_op(0, 32'h600, 0, 5'd10, 1, 1, 0, 1, 0, 0, 3'b001, 1, 32'h00008765, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
